// File: rtl/dmem_pkg.sv
// Shared types and default widths for the SimpleRISC data-memory arbiter.
package dmem_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Which port, if any, receives load data on the cycle after a grant.
  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_CPU  = 2'd1,
    RESP_DBG  = 2'd2
  } resp_t;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating 4-bit counter with synchronous clear and increment, used to
// bound how long a low-priority requester can be held off.
module starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam logic [3:0] LIMIT_C = 4'(LIMIT);

  logic [3:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (inc && (cnt != LIMIT_C)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign at_limit = (cnt == LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: MA stage has priority,
// the debug/loader port wins once it has been starved for STARVE_LIMIT cycles.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,

  output logic              mem_ld,
  output logic              mem_st,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic  starve_at_limit;
  resp_t resp;
  resp_t resp_next;

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (~dbg_req | dbg_gnt),
    .inc      (dbg_req & ~dbg_gnt),
    .at_limit (starve_at_limit)
  );

  // NOTE: every output of this block gets a default first, so no path
  // through the if/else chain can leave a value held and infer a latch.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (dbg_req && starve_at_limit) begin
      dbg_gnt = 1'b1;
    end else if (cpu_req) begin
      cpu_gnt = 1'b1;
    end else if (dbg_req) begin
      dbg_gnt = 1'b1;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Memory side is fully idle (all zero) when nobody is granted.
  always_comb begin
    mem_ld    = 1'b0;
    mem_st    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_ld    = ~cpu_we;
      mem_st    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_ld    = ~dbg_we;
      mem_st    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  always_comb begin
    resp_next = RESP_NONE;
    if (cpu_gnt && !cpu_we) begin
      resp_next = RESP_CPU;
    end else if (dbg_gnt && !dbg_we) begin
      resp_next = RESP_DBG;
    end
  end

  // Read-data registers only load on their own port's granted load and
  // otherwise hold, so software can re-read the last value after rvalid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp      <= RESP_NONE;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      resp <= resp_next;
      if (cpu_gnt && !cpu_we) begin
        cpu_rdata <= mem_rdata;
      end
      if (dbg_gnt && !dbg_we) begin
        dbg_rdata <= mem_rdata;
      end
    end
  end

  assign cpu_rvalid = (resp == RESP_CPU);
  assign dbg_rvalid = (resp == RESP_DBG);

endmodule
